grid_renderer: RTL and testbench

Scans the 30×40 cell bitmap (`grid_ram`) that the ALU-status writer produces and turns it into a pixel stream with Analogue Pocket-style video timing. The block generates its own horizontal and vertical counters and snapshots the bitmap once per frame so the picture cannot tear. It maps each cell to a CELL_W×CELL_H pixel block and outputs 24-bit RGB, data enable and sync pulses. It sits between the grid writer and the core's video output pins.

---
 rtl/grid_renderer.sv | 198 +++++++++++++++++++
 tb/tb_grid_renderer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/grid_renderer.sv
// Grid bitmap to pixel-stream renderer: free-running video timing, per-frame bitmap snapshot, 2-stage output pipe.
// Optional GRID_RENDERER_GRIDLINES_EN draws a 1-pixel border on the top and left of every cell.
module grid_renderer #(
    parameter int unsigned GRID_ROWS = 30,
    parameter int unsigned GRID_COLS = 40,
    parameter int unsigned CELL_W    = 10,
    parameter int unsigned CELL_H    = 12,
    parameter int unsigned H_TOTAL   = 512,
    parameter int unsigned H_BP      = 32,
    parameter int unsigned V_TOTAL   = 400,
    parameter int unsigned V_BP      = 16,
    parameter logic [23:0] ON_COLOR  = 24'hFFFFFF,
    parameter logic [23:0] OFF_COLOR = 24'h000000
`ifdef GRID_RENDERER_GRIDLINES_EN
    ,
    parameter logic [23:0] GRID_COLOR = 24'h404040
`endif
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [GRID_ROWS*GRID_COLS-1:0] grid_ram,
    output logic [23:0]                    vid_rgb,
    output logic                           vid_de,
    output logic                           vid_hs,
    output logic                           vid_vs
);
    localparam int unsigned H_ACTIVE = GRID_COLS * CELL_W;
    localparam int unsigned V_ACTIVE = GRID_ROWS * CELL_H;
    localparam int unsigned NCELL    = GRID_ROWS * GRID_COLS;
    localparam int unsigned HW       = $clog2(H_TOTAL + 1);
    localparam int unsigned VW       = $clog2(V_TOTAL + 1);
    localparam int unsigned PXW      = (CELL_W > 1)    ? $clog2(CELL_W)    : 1;
    localparam int unsigned LNW      = (CELL_H > 1)    ? $clog2(CELL_H)    : 1;
    localparam int unsigned COLW     = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int unsigned ROWW     = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int unsigned BW       = (NCELL > 1)     ? $clog2(NCELL)     : 1;

    localparam logic [HW-1:0]   H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]   H_ACT_LO  = HW'(H_BP);
    localparam logic [HW-1:0]   H_ACT_END = HW'(H_BP + H_ACTIVE - 1);
    localparam logic [VW-1:0]   V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]   V_ACT_LO  = VW'(V_BP);
    localparam logic [VW-1:0]   V_ACT_END = VW'(V_BP + V_ACTIVE - 1);
    localparam logic [PXW-1:0]  PX_LAST   = PXW'(CELL_W - 1);
    localparam logic [LNW-1:0]  LN_LAST   = LNW'(CELL_H - 1);
    localparam logic [COLW-1:0] COL_LAST  = COLW'(GRID_COLS - 1);
    localparam logic [ROWW-1:0] ROW_LAST  = ROWW'(GRID_ROWS - 1);
    localparam logic [BW-1:0]   ROW_STEP  = BW'(GRID_COLS);

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic [PXW-1:0]   px_in_cell;
    logic [COLW-1:0]  col;
    logic [LNW-1:0]   ln_in_cell;
    logic [ROWW-1:0]  row;
    logic [BW-1:0]    row_base;
    logic [NCELL-1:0] snap;

    logic             active_c;
    logic             line_end_c;
    logic             frame_start_c;
    logic [BW-1:0]    cell_idx_c;
    logic [23:0]      pix_c;

    logic             act_q;
    logic             bit_q;
    logic             hs_q;
    logic             vs_q;

    always_comb begin
        active_c      = (h_cnt >= H_ACT_LO) && (h_cnt <= H_ACT_END) &&
                        (v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_END);
        line_end_c    = (h_cnt == H_ACT_END) && (v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_END);
        frame_start_c = (h_cnt == '0) && (v_cnt == '0);
        cell_idx_c    = row_base + BW'(col);
    end

    // Raster counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Horizontal cell tracking; exact multiples mean both trackers land back on 0 at line end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            px_in_cell <= '0;
            col        <= '0;
        end else if (h_cnt == '0) begin
            px_in_cell <= '0;
            col        <= '0;
        end else if (active_c) begin
            if (px_in_cell == PX_LAST) begin
                px_in_cell <= '0;
                col        <= (col == COL_LAST) ? '0 : col + COLW'(1);
            end else begin
                px_in_cell <= px_in_cell + PXW'(1);
            end
        end
    end

    // Vertical cell tracking; row_base replaces a row*GRID_COLS multiply
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ln_in_cell <= '0;
            row        <= '0;
            row_base   <= '0;
        end else if (frame_start_c) begin
            ln_in_cell <= '0;
            row        <= '0;
            row_base   <= '0;
        end else if (line_end_c) begin
            if (ln_in_cell == LN_LAST) begin
                ln_in_cell <= '0;
                if (row == ROW_LAST) begin
                    row      <= '0;
                    row_base <= '0;
                end else begin
                    row      <= row + ROWW'(1);
                    row_base <= row_base + ROW_STEP;
                end
            end else begin
                ln_in_cell <= ln_in_cell + LNW'(1);
            end
        end
    end

    // Frame-coherent copy of the bitmap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap <= '0;
        end else if (frame_start_c) begin
            snap <= grid_ram;
        end
    end

    // Stage 1: cell lookup and timing flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q <= 1'b0;
            bit_q <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            act_q <= active_c;
            bit_q <= snap[cell_idx_c];
            hs_q  <= (h_cnt == '0);
            vs_q  <= frame_start_c;
        end
    end

`ifdef GRID_RENDERER_GRIDLINES_EN
    logic edge_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= (px_in_cell == '0) || (ln_in_cell == '0);
        end
    end
`endif

    always_comb begin
        pix_c = 24'h0;
        if (act_q) begin
            pix_c = bit_q ? ON_COLOR : OFF_COLOR;
`ifdef GRID_RENDERER_GRIDLINES_EN
            if (edge_q) begin
                pix_c = GRID_COLOR;
            end
`endif
        end
    end

    // Stage 2: registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_rgb <= 24'h0;
            vid_de  <= 1'b0;
            vid_hs  <= 1'b0;
            vid_vs  <= 1'b0;
        end else begin
            vid_rgb <= pix_c;
            vid_de  <= act_q;
            vid_hs  <= hs_q;
            vid_vs  <= vs_q;
        end
    end

endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer on a shrunken geometry (3x4 cells of 3x2 px, 16x8 raster).
// A raster-position model predicts every output cycle; frame statistics pin the model with literals.
module tb_grid_renderer;
    localparam int GR = 3, GC = 4, CW = 3, CH = 2;
    localparam int HT = 16, HB = 2, VT = 8, VB = 1;
    localparam int HA = GC * CW, VA = GR * CH, FRAME = HT * VT, NC = GR * GC;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NC-1:0] grid_ram = '0;
    logic [23:0]   vid_rgb;
    logic          vid_de, vid_hs, vid_vs;

    grid_renderer #(
        .GRID_ROWS(GR), .GRID_COLS(GC), .CELL_W(CW), .CELL_H(CH),
        .H_TOTAL(HT), .H_BP(HB), .V_TOTAL(VT), .V_BP(VB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .grid_ram(grid_ram),
        .vid_rgb(vid_rgb), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int nprint = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: clocks since release and the bitmap seen at each frame's first position
    int            edge_cnt = 0;
    logic [NC-1:0] snaps [int];

    always @(posedge clk) begin
        if (!reset_n) begin
            edge_cnt = 0;
        end else begin
            if (edge_cnt % FRAME == 0) snaps[edge_cnt / FRAME] = grid_ram;
            edge_cnt++;
        end
    end

    task automatic model_expect(output logic [23:0] rgb, output logic de, output logic hs,
                                output logic vs);
        int p, h, v, f, x, y;
        logic [NC-1:0] s;
        rgb = 24'h0; de = 1'b0; hs = 1'b0; vs = 1'b0;
        if (reset_n && edge_cnt >= 2) begin
            p  = edge_cnt - 2;
            h  = p % HT;
            v  = (p / HT) % VT;
            f  = p / FRAME;
            hs = (h == 0);
            vs = (h == 0) && (v == 0);
            de = (h >= HB) && (h < HB + HA) && (v >= VB) && (v < VB + VA);
            if (de) begin
                x   = h - HB;
                y   = v - VB;
                s   = snaps[f];
                rgb = s[(y / CH) * GC + x / CW] ? 24'hFFFFFF : 24'h000000;
`ifdef GRID_RENDERER_GRIDLINES_EN
                if ((x % CW == 0) || (y % CH == 0)) rgb = 24'h404040;
`endif
            end
        end
    endtask

    // Frame statistics gathered from the output stream
    int clk_cnt = 0, last_hs = 0, hs_gap = 0;
    bit hs_seen = 0, seen_vs = 0;
    int frames_done = 0, act_line = -1, px = 0;
    int acc_clk = 0, acc_hs = 0, acc_de = 0, acc_white = 0, acc_wx = -1, acc_wy = -1, acc_run = 0;
    int fr_len = 0, fr_hs = 0, fr_de = 0, fr_white = 0, fr_wx = -1, fr_wy = -1, fr_run = 0;

    always @(negedge clk) begin
        logic [23:0] e_rgb;
        logic e_de, e_hs, e_vs;
        model_expect(e_rgb, e_de, e_hs, e_vs);
        checks++;
        if ({vid_rgb, vid_de, vid_hs, vid_vs} !== {e_rgb, e_de, e_hs, e_vs}) begin
            failures++;
            if (nprint < 20) begin
                nprint++;
                $display("FAIL pixel t=%0t edge=%0d actual rgb=%h de=%b hs=%b vs=%b required rgb=%h de=%b hs=%b vs=%b",
                         $time, edge_cnt, vid_rgb, vid_de, vid_hs, vid_vs, e_rgb, e_de, e_hs, e_vs);
            end
        end

        if (!reset_n) begin
            seen_vs  = 0;
            hs_seen  = 0;
            act_line = -1;
            px       = 0;
        end else begin
            if (vid_hs) begin
                if (hs_seen) hs_gap = clk_cnt - last_hs;
                last_hs = clk_cnt;
                hs_seen = 1;
            end
            if (vid_vs) begin
                if (seen_vs) begin
                    fr_len = acc_clk; fr_hs = acc_hs; fr_de = acc_de; fr_white = acc_white;
                    fr_wx = acc_wx; fr_wy = acc_wy; fr_run = acc_run;
                    frames_done++;
                end
                seen_vs = 1;
                acc_clk = 0; acc_hs = 0; acc_de = 0; acc_white = 0; acc_run = 0;
                acc_wx = -1; acc_wy = -1; act_line = -1;
            end
            if (vid_hs) begin
                acc_hs++;
                px = 0;
            end
            if (vid_de) begin
                if (px == 0) act_line++;
                acc_de++;
                if (vid_rgb == 24'hFFFFFF) begin
                    acc_white++;
                    if (acc_wx < 0) begin
                        acc_wx = px;
                        acc_wy = act_line;
                    end
                end
                px++;
                if (px > acc_run) acc_run = px;
            end
            acc_clk++;
            clk_cnt++;
        end
    end

    task automatic wait_frames(input int n);
        int target = frames_done + n;
        int budget = (n + 1) * FRAME + 10;
        while (frames_done < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        check("frame_wait", (frames_done >= target) ? 1 : 0, 1);
    endtask

    task automatic release_and_check_first_sync(input string tag);
        @(posedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1 check({tag, "_hs_edge1"}, vid_hs, 0);
        @(posedge clk); #1 check({tag, "_hs_edge2"}, vid_hs, 1);
        check({tag, "_vs_edge2"}, vid_vs, 1);
    endtask

    initial begin
        int budget;
        reset_n  = 1'b0;
        grid_ram = '0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_rgb", vid_rgb, 0);
        check("reset_de", vid_de, 0);
        check("reset_hs", vid_hs, 0);
        check("reset_vs", vid_vs, 0);

        release_and_check_first_sync("boot");
        wait_frames(1);
        check("blank_len", fr_len, FRAME);
        check("blank_hs", fr_hs, 8);
        check("blank_de", fr_de, 72);
        check("blank_white", fr_white, 0);
        check("hs_gap", hs_gap, 16);
        check("de_run", fr_run, 12);

        grid_ram = 12'h001;
        wait_frames(2);
        check("tl_white", fr_white, 6);
        check("tl_x", fr_wx, 0);
        check("tl_y", fr_wy, 0);

        grid_ram = 12'h800;
        wait_frames(2);
        check("br_white", fr_white, 6);
        check("br_x", fr_wx, 9);
        check("br_y", fr_wy, 4);
        check("br_de", fr_de, 72);

        grid_ram = 12'hA69;
        wait_frames(2);
        check("pattern_white", fr_white, 36);

        grid_ram = 12'h000;
        wait_frames(2);
        budget = FRAME;
        while (act_line < 3 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        check("midframe_reached", (act_line >= 3) ? 1 : 0, 1);
        grid_ram = 12'h020;
        wait_frames(1);
        check("tear_white", fr_white, 0);
        wait_frames(1);
        check("next_white", fr_white, 6);
        check("next_x", fr_wx, 3);
        check("next_y", fr_wy, 2);

        budget = FRAME;
        while (!vid_de && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        check("de_reached", vid_de, 1);
        reset_n = 1'b0;
        #1;
        check("midreset_de", vid_de, 0);
        check("midreset_rgb", vid_rgb, 0);
        repeat (2) @(posedge clk);
        release_and_check_first_sync("rerun");
        wait_frames(1);
        check("rerun_len", fr_len, FRAME);
        check("rerun_de", fr_de, 72);
        check("rerun_white", fr_white, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
